// File: rtl/voice_mix_sequencer.sv
// Once per sample frame, runs each unmuted voice through a start/finish handshake, applies its gain
// on the shared multiplier, sums the results, then scales and saturates the mix into one output sample.
module voice_mix_sequencer #(
  parameter int NUM_VOICES   = 8,
  parameter int WAVE_W       = 24,
  parameter int GAIN_W       = 8,
  parameter int ACC_W        = 32,
  parameter int MASTER_SHIFT = 1,
  parameter int MULT_LAT     = 2,
  parameter int SEL_W        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         next_sample,
  output logic [NUM_VOICES-1:0]        voice_start,
  input  logic [NUM_VOICES-1:0]        voice_finish,
  input  logic [NUM_VOICES*WAVE_W-1:0] voice_wave,
  input  logic [NUM_VOICES-1:0]        mute,
  input  logic                         gain_wr_en,
  input  logic [SEL_W-1:0]             gain_wr_addr,
  input  logic [GAIN_W-1:0]            gain_wr_data,
  output logic [SEL_W-1:0]             mult_sel,
  output logic                         mult_own,
  output logic [31:0]                  mult_a,
  output logic [31:0]                  mult_b,
  input  logic [63:0]                  mult_p,
  output logic [WAVE_W-1:0]            wave_out,
  output logic                         wave_valid,
  output logic                         busy,
  output logic                         overrun
);
  localparam int IDX_W  = $clog2(NUM_VOICES + 1);
  localparam int WAIT_W = 8;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(1 << (GAIN_W - 1));
  localparam longint SAT_MAX_L = (longint'(1) << (WAVE_W - 1)) - 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(SAT_MAX_L);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-SAT_MAX_L - 1);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_RUN, S_GAIN, S_WAIT, S_ACC, S_OUT} state_t;

  state_t                    state_reg, state_next;
  logic [IDX_W-1:0]          idx_reg;
  logic [NUM_VOICES-1:0]     mute_reg;
  logic signed [ACC_W-1:0]   acc_reg;
  logic signed [WAVE_W-1:0]  wave_reg;
  logic [GAIN_W-1:0]         gain_hold_reg;
  logic [WAIT_W-1:0]         wait_cnt_reg;
  logic [WAVE_W-1:0]         wave_out_reg;
  logic                      overrun_reg;
  logic [GAIN_W-1:0]         gain_mem [NUM_VOICES];
  logic signed [WAVE_W-1:0]  wave_arr [NUM_VOICES];

  logic [SEL_W-1:0]          sel;
  logic [GAIN_W-1:0]         gain_sel;
  logic signed [ACC_W-1:0]   acc_inc;
  logic signed [ACC_W-1:0]   scaled;
  logic [WAVE_W-1:0]         sat_val;
  logic                      idx_done;

  assign sel      = idx_reg[SEL_W-1:0];
  assign idx_done = (idx_reg == IDX_W'(NUM_VOICES));
  assign mult_sel = sel;
  assign overrun  = overrun_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      assign wave_arr[gi]    = voice_wave[gi*WAVE_W +: WAVE_W];
      assign voice_start[gi] = (state_reg == S_RUN) && (sel == SEL_W'(gi));
    end
  endgenerate

  // Gain is read live in GAIN and then held so a later write cannot disturb an in-flight product.
  assign gain_sel = (state_reg == S_GAIN) ? gain_mem[sel] : gain_hold_reg;
  assign mult_a   = {{(32 - WAVE_W){wave_reg[WAVE_W-1]}}, wave_reg};
  assign mult_b   = {{(32 - GAIN_W){1'b0}}, gain_sel};
  assign acc_inc  = ACC_W'($signed(mult_p) >>> (GAIN_W - 1));
  assign scaled   = acc_reg >>> MASTER_SHIFT;

  always_comb begin
    sat_val = WAVE_W'(scaled);
    if (scaled > SAT_MAX)      sat_val = WAVE_W'(SAT_MAX);
    else if (scaled < SAT_MIN) sat_val = WAVE_W'(SAT_MIN);
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    mult_own   = 1'b0;
    wave_valid = 1'b0;
    busy       = (state_reg != S_IDLE);
    wave_out   = wave_out_reg;
    case (state_reg)
      S_IDLE: if (next_sample) state_next = S_SCAN;
      S_SCAN: begin
        if (idx_done)            state_next = S_OUT;
        else if (!mute_reg[sel]) state_next = S_RUN;
      end
      S_RUN: begin
        mult_own = 1'b1;
        if (voice_finish[sel]) state_next = S_GAIN;
      end
      S_GAIN: state_next = (MULT_LAT > 1) ? S_WAIT : S_ACC;
      S_WAIT: if (wait_cnt_reg == WAIT_W'(MULT_LAT - 2)) state_next = S_ACC;
      S_ACC:  state_next = S_SCAN;
      S_OUT: begin
        wave_valid = 1'b1;
        wave_out   = sat_val;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg       <= '0;
      mute_reg      <= '0;
      acc_reg       <= '0;
      wave_reg      <= '0;
      gain_hold_reg <= '0;
      wait_cnt_reg  <= '0;
      wave_out_reg  <= '0;
      overrun_reg   <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) gain_mem[i] <= GAIN_UNITY;
    end else begin
      overrun_reg <= next_sample && (state_reg != S_IDLE);
      if (gain_wr_en && (int'(gain_wr_addr) < NUM_VOICES)) gain_mem[gain_wr_addr] <= gain_wr_data;
      case (state_reg)
        S_IDLE: if (next_sample) begin
          mute_reg <= mute;
          acc_reg  <= '0;
          idx_reg  <= '0;
        end
        S_SCAN: if (!idx_done && mute_reg[sel]) idx_reg <= idx_reg + 1'b1;
        S_RUN:  if (voice_finish[sel]) wave_reg <= wave_arr[sel];
        S_GAIN: begin
          gain_hold_reg <= gain_mem[sel];
          wait_cnt_reg  <= '0;
        end
        S_WAIT: wait_cnt_reg <= wait_cnt_reg + 1'b1;
        S_ACC: begin
          acc_reg <= acc_reg + acc_inc;
          idx_reg <= idx_reg + 1'b1;
        end
        S_OUT:  wave_out_reg <= sat_val;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_voice_mix_sequencer.sv
// Randomized frames against a sum-of-products mix model; voice responders and the shared multiplier live here.
module tb_voice_mix_sequencer;
  logic         clk = 0;
  logic         rst = 1;
  logic         next_sample = 0;
  logic [7:0]   voice_start;
  logic [7:0]   voice_finish = 0;
  logic [191:0] voice_wave = 0;
  logic [7:0]   mute = 0;
  logic         gain_wr_en = 0;
  logic [2:0]   gain_wr_addr = 0;
  logic [7:0]   gain_wr_data = 0;
  logic [2:0]   mult_sel;
  logic         mult_own;
  logic [31:0]  mult_a, mult_b;
  logic [63:0]  mult_p;
  logic [23:0]  wave_out;
  logic         wave_valid, busy, overrun;

  int checks = 0;
  int failures = 0;

  logic signed [23:0] wv [8];
  int                 run_len [8];
  logic [7:0]         gshadow [8];
  logic [7:0]         gu [8];
  logic signed [63:0] p1 = 0, p2 = 0;

  voice_mix_sequencer dut (
    .clk(clk), .rst(rst), .next_sample(next_sample), .voice_start(voice_start),
    .voice_finish(voice_finish), .voice_wave(voice_wave), .mute(mute),
    .gain_wr_en(gain_wr_en), .gain_wr_addr(gain_wr_addr), .gain_wr_data(gain_wr_data),
    .mult_sel(mult_sel), .mult_own(mult_own), .mult_a(mult_a), .mult_b(mult_b),
    .mult_p(mult_p), .wave_out(wave_out), .wave_valid(wave_valid), .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Two-stage pipelined multiplier standing in for the shared unit.
  always @(posedge clk) begin
    p1 <= $signed(mult_a) * $signed(mult_b);
    p2 <= p1;
  end
  assign mult_p = p2;

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] mix_exp(input logic [7:0] m);
    longint acc = 0;
    longint s;
    for (int v = 0; v < 8; v++)
      if (!m[v]) acc += (longint'(wv[v]) * longint'(gu[v])) >>> 7;
    s = acc >>> 1;
    if (s > 64'sd8388607)  s = 64'sd8388607;
    if (s < -64'sd8388608) s = -64'sd8388608;
    return 24'(s);
  endfunction

  task automatic set_waves(input logic signed [23:0] fixed, input bit use_fixed);
    for (int i = 0; i < 8; i++) begin
      wv[i]      = use_fixed ? fixed : 24'($urandom);
      run_len[i] = $urandom_range(1, 4);
      voice_wave[i*24 +: 24] = wv[i];
    end
  endtask

  task automatic write_gain(input int v, input logic [7:0] d);
    gain_wr_en = 1; gain_wr_addr = 3'(v); gain_wr_data = d;
    tick();
    gain_wr_en = 0;
    gshadow[v] = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_start"}, voice_start, 0);
    check_val({tag, "_own"}, mult_own, 0);
    check_val({tag, "_wave"}, wave_out, 0);
    check_val({tag, "_valid"}, wave_valid, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_ovr"}, overrun, 0);
  endtask

  // One frame: wr_k>=0 writes gain[wr_v]=wr_d in voice wr_k's first RUN cycle; ovr_at>=0 sends an
  // extra next_sample at that busy cycle; rst_k>=0 resets when voice rst_k starts running.
  task automatic run_frame(input string tag, input logic [7:0] mute_v, input int wr_k, input int wr_v,
                           input logic [7:0] wr_d, input int ovr_at, input int rst_k);
    int busy_cnt = 0, valid_cnt = 0, ovr_cnt = 0, bad_cnt = 0, run_cnt = 0, act, exp_busy = 2;
    bit done = 0, aborted = 0;
    bit seen [8];
    logic [23:0] got = 0, exp_w;
    logic [7:0] act_mask, fin;
    for (int v = 0; v < 8; v++) begin
      gu[v] = gshadow[v];
      seen[v] = 0;
      exp_busy += mute_v[v] ? 1 : run_len[v] + 4;
    end
    if (wr_k >= 0 && wr_v >= wr_k) gu[wr_v] = wr_d;
    exp_w = mix_exp(mute_v);
    next_sample = 1; mute = mute_v;
    tick();
    next_sample = 0; mute = 8'($urandom);
    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      gain_wr_en = 0; next_sample = 0;
      if (busy) busy_cnt++;
      if (overrun) ovr_cnt++;
      if (wave_valid) begin valid_cnt++; got = wave_out; end
      if ((voice_start & mute_v) != 0) bad_cnt++;
      if (voice_start != 0 && !$onehot(voice_start)) bad_cnt++;
      if (mult_own != (voice_start != 0)) bad_cnt++;
      if (ovr_at >= 0 && cyc == ovr_at) next_sample = 1;
      act = -1;
      for (int i = 0; i < 8; i++) if (voice_start[i]) act = i;
      act_mask = 0; fin = 0;
      if (act >= 0) begin
        act_mask = 8'(1 << act);
        if (mult_sel != 3'(act)) bad_cnt++;
        if (!seen[act]) begin
          seen[act] = 1;
          if (act == rst_k) begin
            rst = 1; voice_finish = 0;
            tick();
            rst = 0;
            check_reset_outputs({tag, "_rst"});
            for (int v = 0; v < 8; v++) gshadow[v] = 8'h80;
            aborted = 1; done = 1;
          end else if (act == wr_k) begin
            gain_wr_en = 1; gain_wr_addr = 3'(wr_v); gain_wr_data = wr_d;
          end
        end
        run_cnt++;
        if (run_cnt == run_len[act]) fin = act_mask;
      end else run_cnt = 0;
      if (!aborted) begin
        voice_finish = fin | (8'($urandom) & ~act_mask);
        if (!busy) done = 1;
        else tick();
      end
    end
    voice_finish = 0; gain_wr_en = 0; next_sample = 0;
    if (!done) check_val({tag, "_timeout"}, 1, 0);
    else if (!aborted) begin
      check_val({tag, "_wave"}, got, exp_w);
      check_val({tag, "_held"}, wave_out, exp_w);
      check_val({tag, "_valid_cnt"}, valid_cnt, 1);
      check_val({tag, "_busy_cyc"}, busy_cnt, exp_busy);
      check_val({tag, "_ovr_cnt"}, ovr_cnt, (ovr_at >= 0) ? 1 : 0);
      check_val({tag, "_protocol"}, bad_cnt, 0);
      if (wr_k >= 0) gshadow[wr_v] = wr_d;
      $display("frame %s mute=%02h wave_out=%06h exp=%06h busy=%0d", tag, mute_v, got, exp_w, busy_cnt);
    end else
      $display("frame %s aborted by reset", tag);
  endtask

  initial begin
    logic [7:0] m;
    int k, v;
    for (int i = 0; i < 8; i++) gshadow[i] = 8'h80;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 0;
    tick();

    set_waves(24'sh100000, 1);
    run_len[0] = 3;
    run_frame("t1_unity", 8'hFE, -1, 0, 0, -1, -1);
    check_val("t1_const", wave_out, 24'h080000);

    for (int i = 0; i < 8; i++) write_gain(i, 8'hFF);
    set_waves(24'sh7FFFFF, 1);
    run_frame("t2_sat_pos", 8'h00, -1, 0, 0, -1, -1);
    check_val("t2_pos_const", wave_out, 24'h7FFFFF);
    set_waves(-24'sh800000, 1);
    run_frame("t2_sat_neg", 8'h00, -1, 0, 0, -1, -1);
    check_val("t2_neg_const", wave_out, 24'h800000);
    for (int i = 0; i < 8; i++) write_gain(i, 8'h80);

    set_waves(0, 0);
    run_frame("t3_mute", 8'h04, -1, 0, 0, -1, -1);
    set_waves(0, 0);
    run_frame("t4_overrun", 8'h00, -1, 0, 0, 4, -1);
    write_gain(5, 8'h33);
    set_waves(0, 0);
    run_frame("t5_reset", 8'h00, -1, 0, 0, -1, 3);
    set_waves(0, 0);
    run_frame("t5_after", 8'h00, -1, 0, 0, -1, -1);

    set_waves(0, 0);
    run_frame("t6_race_v1", 8'h00, 1, 1, 8'h40, -1, -1);
    set_waves(0, 0);
    run_frame("t6_late_v0", 8'h00, 2, 0, 8'h20, -1, -1);
    set_waves(0, 0);
    run_frame("t6_next", 8'h00, -1, 0, 0, -1, -1);

    for (int f = 0; f < 10; f++) begin
      m = 8'($urandom);
      if (m == 8'hFF && f % 2 == 0) m = 8'h7F;
      k = -1;
      v = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1)
        for (int i = 0; i < 8; i++) if (!m[i] && k < 0 && $urandom_range(0, 2) != 0) k = i;
      set_waves(0, 0);
      run_frame($sformatf("rand%0d", f), m, k, v, 8'($urandom), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
